mem_bus_sequencer: RTL and testbench



---
 rtl/mem_bus_sequencer_if.sv | 26 ++
 rtl/mem_bus_sequencer.sv | 108 ++++++++++
 tb/tb_mem_bus_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_sequencer_if.sv
// rtl/mem_bus_sequencer_if.sv - core request/response and scratch-memory bus bundle for mem_bus_sequencer
interface mem_bus_sequencer_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  memWriteReq;
    logic [ADDR_WIDTH-1:0] memReqBus;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, memWriteReq, memReqBus
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, memWriteReq, memReqBus
    );
endinterface

// File: rtl/mem_bus_sequencer.sv
// rtl/mem_bus_sequencer.sv - serialises core loads/stores onto the two-phase scratch-memory bus (optional skid: MEM_BUS_SKID_EN)
module mem_bus_sequencer #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WR_DATA, WR_ADDR, RD} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] lat_addr;

    logic                  accept;
    logic                  src_valid;
    logic                  src_write;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0] src_wdata;

`ifdef MEM_BUS_SKID_EN
    logic                  skid_full;
    logic                  skid_write;
    logic [ADDR_WIDTH-1:0] skid_addr;
    logic [DATA_WIDTH-1:0] skid_wdata;
`endif

    // Choose the request to launch next: a parked request has priority, otherwise a live handshake taken in IDLE
    always_comb begin
        accept = bus.req_valid & bus.req_ready;
`ifdef MEM_BUS_SKID_EN
        if (skid_full) begin
            src_valid = 1'b1;
            src_write = skid_write;
            src_addr  = skid_addr;
            src_wdata = skid_wdata;
        end else begin
            src_valid = accept & (state == IDLE);
            src_write = bus.req_write;
            src_addr  = bus.req_addr;
            src_wdata = bus.req_wdata;
        end
`else
        src_valid = accept;
        src_write = bus.req_write;
        src_addr  = bus.req_addr;
        src_wdata = bus.req_wdata;
`endif
    end

    // Sequencer FSM; every bus and response output is registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            lat_addr        <= '0;
            bus.req_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.memWriteReq <= 1'b0;
            bus.memReqBus   <= '0;
`ifdef MEM_BUS_SKID_EN
            skid_full       <= 1'b0;
            skid_write      <= 1'b0;
            skid_addr       <= '0;
            skid_wdata      <= '0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            // Memory read data is combinational on the address driven during RD
            if (state == RD) begin
                bus.rsp_rdata <= bus.mem_read_data;
                bus.rsp_valid <= 1'b1;
            end

            // WR_DATA always hands over to its address phase, so memWriteReq can never stay high
            if (state == WR_DATA) begin
                state           <= WR_ADDR;
                bus.memWriteReq <= 1'b0;
                bus.memReqBus   <= lat_addr;
            end else if (src_valid) begin
                lat_addr        <= src_addr;
                bus.memWriteReq <= src_write;
                bus.memReqBus   <= src_write ? ADDR_WIDTH'(src_wdata) : src_addr;
                state           <= src_write ? WR_DATA : RD;
            end else begin
                state           <= IDLE;
                bus.memWriteReq <= 1'b0;
                bus.memReqBus   <= '0;
            end

`ifdef MEM_BUS_SKID_EN
            // A request taken while the FSM is busy waits in the skid; ready simply mirrors skid emptiness
            if (accept && (state != IDLE)) begin
                skid_full     <= 1'b1;
                skid_write    <= bus.req_write;
                skid_addr     <= bus.req_addr;
                skid_wdata    <= bus.req_wdata;
                bus.req_ready <= 1'b0;
            end else if (skid_full && (state != WR_DATA)) begin
                skid_full     <= 1'b0;
                bus.req_ready <= 1'b1;
            end
`else
            bus.req_ready <= (state != WR_DATA) && !src_valid;
`endif
        end
    end
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// tb/tb_mem_bus_sequencer.sv - self-checking bench for mem_bus_sequencer with scratch-memory model and response scoreboard
module tb_mem_bus_sequencer;
    localparam int AW = 15;
    localparam int DW = 8;
`ifdef MEM_BUS_SKID_EN
    localparam int CADENCE = 2;
    localparam int ACC_GAP = 1;
`else
    localparam int CADENCE = 3;
    localparam int ACC_GAP = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_bus_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Scratch memory: data phase latches the byte, following address phase commits it
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          wr_pend;
    logic [DW-1:0] wr_q;

    assign bus.mem_read_data = mem[bus.memReqBus];

    initial for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            wr_pend <= 1'b0;
        end else begin
            if (wr_pend) mem[bus.memReqBus] <= wr_q;
            wr_pend <= bus.memWriteReq;
            if (bus.memWriteReq) wr_q <= bus.memReqBus[DW-1:0];
        end
    end

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_count = 0;
    int consec_err = 0;
    logic prev_mwr = 1'b0;
    logic [DW-1:0] exp_q [$];
    int wr_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.memWriteReq) begin
            wr_cyc.push_back(cyc);
            if (prev_mwr) consec_err++;
        end
        prev_mwr = bus.memWriteReq;
        if (bus.rsp_valid) rsp_count++;
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit upd);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            checks++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        if (w) begin
            if (upd) ref_mem[a] = d;
        end else begin
            exp_q.push_back(ref_mem[a]);
        end
    endtask

    // Waits for the next response pulse and scores it against the oldest expected load result
    task automatic expect_rsp(input string name);
        int n;
        logic [DW-1:0] e;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (!bus.rsp_valid) begin
            $display("FAIL %s_timeout: rsp_valid=%b, required 1", name, bus.rsp_valid);
        end else if (exp_q.size() == 0) begin
            $display("FAIL %s_unexpected: rsp_rdata=%h with no load outstanding", name, bus.rsp_rdata);
        end else begin
            e = exp_q.pop_front();
            if (bus.rsp_rdata !== e) $display("FAIL %s: rsp_rdata=%h, required %h", name, bus.rsp_rdata, e);
            else passes++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 15'h1234;
        bus.req_wdata = 8'hFF;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        checks++; if (bus.memWriteReq !== 1'b0) $display("FAIL reset_mwr: got %b, required 0", bus.memWriteReq); else passes++;
        checks++; if (bus.memReqBus !== 15'h0) $display("FAIL reset_bus: got %h, required 0000", bus.memReqBus); else passes++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); else passes++;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.req_ready); else passes++;
        checks++; if (bus.rsp_rdata !== 8'h00) $display("FAIL reset_rdata: got %h, required 00", bus.rsp_rdata); else passes++;
        idle_cycles(1);
    endtask

    task automatic test_store_then_load();
        int rc0;
        issue(1'b1, 15'h1234, 8'hA5, 1'b1);
        @(negedge clk);
        checks++; if (bus.memWriteReq !== 1'b1) $display("FAIL store_data_mwr: got %b, required 1", bus.memWriteReq); else passes++;
        checks++; if (bus.memReqBus !== 15'h00A5) $display("FAIL store_data_bus: got %h, required 00a5", bus.memReqBus); else passes++;
        @(negedge clk);
        checks++; if (bus.memWriteReq !== 1'b0) $display("FAIL store_addr_mwr: got %b, required 0", bus.memWriteReq); else passes++;
        checks++; if (bus.memReqBus !== 15'h1234) $display("FAIL store_addr_bus: got %h, required 1234", bus.memReqBus); else passes++;
        @(posedge clk); #1;
        checks++; if (mem[15'h1234] !== 8'hA5) $display("FAIL store_commit: mem=%h, required a5", mem[15'h1234]); else passes++;
        rc0 = rsp_count;
        issue(1'b0, 15'h1234, 8'h00, 1'b1);
        expect_rsp("load_after_store");
        idle_cycles(3);
        checks++; if (bus.rsp_rdata !== 8'hA5) $display("FAIL rdata_hold: got %h, required a5", bus.rsp_rdata); else passes++;
        checks++; if (rsp_count - rc0 !== 1) $display("FAIL rsp_pulse_count: got %0d, required 1", rsp_count - rc0); else passes++;
    endtask

    task automatic test_boundary();
        issue(1'b1, 15'h7FFF, 8'h3C, 1'b1);
        issue(1'b1, 15'h0000, 8'hC3, 1'b1);
        issue(1'b0, 15'h7FFF, 8'h00, 1'b1);
        expect_rsp("load_7fff");
        issue(1'b0, 15'h0000, 8'h00, 1'b1);
        expect_rsp("load_0000");
        checks++; if (mem[15'h7FFF] !== 8'h3C) $display("FAIL mem_7fff: got %h, required 3c", mem[15'h7FFF]); else passes++;
        checks++; if (mem[15'h0000] !== 8'hC3) $display("FAIL mem_0000: got %h, required c3", mem[15'h0000]); else passes++;
    endtask

    task automatic test_reset_mid_op();
        int rc0;
        logic [DW-1:0] dummy;
        issue(1'b1, 15'h0555, 8'h5A, 1'b1);
        idle_cycles(3);
        rc0 = rsp_count;
        issue(1'b1, 15'h0555, 8'hEE, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus.memWriteReq !== 1'b0) $display("FAIL midstore_mwr: got %b, required 0", bus.memWriteReq); else passes++;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL midstore_ready: got %b, required 1", bus.req_ready); else passes++;
        issue(1'b0, 15'h0555, 8'h00, 1'b1);
        expect_rsp("load_after_abandon");
        issue(1'b0, 15'h0555, 8'h00, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dummy = exp_q.pop_back();
        idle_cycles(3);
        checks++; if (rsp_count - rc0 !== 1) $display("FAIL midop_rsp_count: got %0d, required 1", rsp_count - rc0); else passes++;
        checks++; if (mem[15'h0555] !== 8'h5A) $display("FAIL midstore_mem: got %h, required 5a (last dropped %h)", mem[15'h0555], dummy); else passes++;
    endtask

    task automatic test_back_to_back();
        int base;
        int c1;
        int c2;
        base = wr_cyc.size();
        issue(1'b1, 15'h0010, 8'h11, 1'b1);
        c1 = acc_cyc;
        issue(1'b1, 15'h0020, 8'h22, 1'b1);
        c2 = acc_cyc;
        issue(1'b1, 15'h0030, 8'h33, 1'b1);
        idle_cycles(5);
        checks++; if (c2 - c1 !== ACC_GAP) $display("FAIL accept_gap: got %0d, required %0d", c2 - c1, ACC_GAP); else passes++;
        checks++;
        if (wr_cyc.size() < base + 3) begin
            $display("FAIL wr_phase_count: got %0d, required %0d", wr_cyc.size() - base, 3);
        end else begin
            passes++;
            checks++; if (wr_cyc[base+1] - wr_cyc[base] !== CADENCE) $display("FAIL cadence_12: got %0d, required %0d", wr_cyc[base+1] - wr_cyc[base], CADENCE); else passes++;
            checks++; if (wr_cyc[base+2] - wr_cyc[base+1] !== CADENCE) $display("FAIL cadence_23: got %0d, required %0d", wr_cyc[base+2] - wr_cyc[base+1], CADENCE); else passes++;
        end
        issue(1'b0, 15'h0010, 8'h00, 1'b1);
        expect_rsp("rb_10");
        issue(1'b0, 15'h0020, 8'h00, 1'b1);
        expect_rsp("rb_20");
        issue(1'b0, 15'h0030, 8'h00, 1'b1);
        expect_rsp("rb_30");
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_store_then_load();
        test_boundary();
        test_reset_mid_op();
        test_back_to_back();
        idle_cycles(2);
        checks++; if (consec_err !== 0) $display("FAIL mwr_consecutive: got %0d, required 0", consec_err); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d, required 0", exp_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
